// File: rtl/hs_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hs_ram_arbiter                                                    |
// | Brief  : Pauses the CPU and shares the work-RAM port round-robin between   |
// |          byte-wide requesters.                                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module hs_ram_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 16,
  parameter int SETTLE = 4,
  parameter int RD_LAT = 1,
  parameter int HOLD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_wdata,
  output logic [NREQ-1:0]  ack,
  output logic [7:0]       rdata,
  output logic             pause_req,
  input  logic             cpu_paused,
  output logic             ram_access,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [7:0]       ram_wdata,
  input  logic [7:0]       ram_rdata,
  output logic             busy
);

  localparam int c_iw     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cmax_a = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int c_cmax   = (c_cmax_a > RD_LAT + 1) ? c_cmax_a : RD_LAT + 1;
  localparam int c_cw     = $clog2(c_cmax + 1);

  localparam logic [c_cw-1:0] c_settle_ld = c_cw'(SETTLE - 1);
  localparam logic [c_cw-1:0] c_hold_ld   = c_cw'(HOLD - 1);
  localparam logic [c_cw-1:0] c_rdlat_ld  = c_cw'(RD_LAT);
  localparam logic [c_iw:0]   c_nreq      = (c_iw + 1)'(NREQ);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PAUSE_WAIT = 3'd1,
    S_SETTLE     = 3'd2,
    S_ARB        = 3'd3,
    S_ACCESS     = 3'd4,
    S_HOLD       = 3'd5
  } state_t;

  state_t            r_state, w_state_n;
  logic [c_cw-1:0]   r_cnt, w_cnt_n;
  logic [c_iw-1:0]   r_rr, w_rr_n;
  logic [c_iw-1:0]   r_g;
  logic [AW-1:0]     r_addr;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic [NREQ-1:0]   r_ack;
  logic [7:0]        r_rdata;
  logic              r_pause;

  logic [NREQ-1:0]   w_elig;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic              w_found;
  logic [c_iw-1:0]   w_off;
  logic [c_iw:0]     w_sum;
  logic [c_iw-1:0]   w_gidx;
  logic [c_iw:0]     w_gp1;
  logic              w_grant;
  logic              w_done;

  // The just-acked requester is masked for one cycle so it can keep req high to re-arm.
  assign w_elig = req & ~r_ack;
  assign w_dbl  = {w_elig, w_elig} >> r_rr;
  assign w_rot  = w_dbl[NREQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = c_iw'(k);
      end
    end
  end

  assign w_sum  = {1'b0, r_rr} + {1'b0, w_off};
  assign w_gidx = (w_sum >= c_nreq) ? c_iw'(w_sum - c_nreq) : w_sum[c_iw-1:0];
  assign w_gp1  = {1'b0, w_gidx} + {{c_iw{1'b0}}, 1'b1};

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rr_n    = r_rr;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) w_state_n = S_PAUSE_WAIT;
      end
      S_PAUSE_WAIT: begin
        if (cpu_paused) begin
          w_state_n = S_SETTLE;
          w_cnt_n   = c_settle_ld;
        end else if (!(|req)) begin
          w_state_n = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!cpu_paused)        w_state_n = S_PAUSE_WAIT;
        else if (r_cnt == '0)   w_state_n = S_ARB;
        else                    w_cnt_n   = r_cnt - 1'b1;
      end
      S_ARB: begin
        if (w_found) begin
          w_grant   = 1'b1;
          w_rr_n    = (w_gp1 == c_nreq) ? '0 : w_gp1[c_iw-1:0];
          w_state_n = S_ACCESS;
          w_cnt_n   = c_rdlat_ld;
        end else begin
          w_state_n = S_HOLD;
          w_cnt_n   = c_hold_ld;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_done = 1'b1;
          if (cpu_paused) begin
            w_state_n = S_HOLD;
            w_cnt_n   = c_hold_ld;
          end else begin
            w_state_n = S_PAUSE_WAIT;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (|w_elig)            w_state_n = S_ARB;
        else if (!cpu_paused)   w_state_n = S_PAUSE_WAIT;
        else if (r_cnt == '0)   w_state_n = S_IDLE;
        else                    w_cnt_n   = r_cnt - 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rr    <= '0;
      r_g     <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_pause <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rr    <= w_rr_n;
      r_pause <= (w_state_n != S_IDLE);
      r_ack   <= '0;
      if (w_grant) begin
        r_g     <= w_gidx;
        r_addr  <= req_addr[w_gidx*AW +: AW];
        r_we    <= req_we[w_gidx];
        r_wdata <= req_wdata[w_gidx*8 +: 8];
      end
      if (w_done) begin
        r_ack[r_g] <= 1'b1;
        if (!r_we) r_rdata <= ram_rdata;
      end
    end
  end

  assign ack        = r_ack;
  assign rdata      = r_rdata;
  assign pause_req  = r_pause;
  assign busy       = (r_state != S_IDLE);
  assign ram_access = (r_state == S_ACCESS);
  // The write strobe is confined to the first access cycle.
  assign ram_we     = ram_access & r_we & (r_cnt == c_rdlat_ld);
  assign ram_addr   = ram_access ? r_addr : '0;
  assign ram_wdata  = ram_we ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_hs_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hs_ram_arbiter                                                 |
// | Brief  : Directed self-checking bench for hs_ram_arbiter.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_hs_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_we;
  logic [15:0] addr0, addr1;
  logic [7:0]  wd0, wd1;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        pause_req, cpu_paused;
  logic        ram_access, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        busy;

  logic [1:0]  r_pdly;
  logic        man_mode, man_paused;
  int          we_cnt;
  logic [15:0] we_addr;
  logic [7:0]  we_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  hs_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we),
    .req_addr({addr1, addr0}), .req_wdata({wd1, wd0}),
    .ack(ack), .rdata(rdata),
    .pause_req(pause_req), .cpu_paused(cpu_paused),
    .ram_access(ram_access), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // CPU pause model: halts two cycles after pause_req, unless driven by hand.
  always @(posedge clk) r_pdly <= {r_pdly[0], pause_req};
  assign cpu_paused = man_mode ? man_paused : r_pdly[1];

  // RAM model with one cycle of read latency.
  always @(posedge clk)
    ram_rdata <= (ram_addr == 16'h6000) ? 8'h5A :
                 (ram_addr == 16'h6001) ? 8'h77 : 8'h00;

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_data <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until an ack appears; reports steps to first access, to ack, and pause_req-low cycles.
  task automatic run(input int maxc, output int n_acc, output int n_ack, output int n_plow);
    n_acc = -1; n_ack = -1; n_plow = 0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (!pause_req) n_plow++;
      if (ram_access && n_acc < 0) n_acc = i;
      if (ack != 2'b00) begin
        n_ack = i;
        break;
      end
    end
    if (n_ack < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int na, nk, np, k, prev_plow;
  logic [1:0] exp_ack;

  initial begin
    reset = 1'b1; req = '0; req_we = '0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    man_mode = 1'b0; man_paused = 1'b0;
    we_cnt = 0; we_addr = '0; we_data = '0;
    step(); step();
    check("rst_ack",   {30'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_pause", {31'd0, pause_req}, 32'd0);
    check("rst_access",{31'd0, ram_access}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // Single read from requester 0.
    addr0 = 16'h6000; req = 2'b01;
    step();
    check("rd_pause_1cyc", {31'd0, pause_req}, 32'd1);
    run(40, na, nk, np);
    check("rd_first_access", na, 8);
    check("rd_ack_cycle",    nk, 10);
    check("rd_ack",          {30'd0, ack}, 32'd1);
    check("rd_rdata",        {24'd0, rdata}, 32'h5A);
    check("rd_no_we",        we_cnt, 0);
    req = 2'b00;

    // Write from requester 1, served straight from HOLD.
    req_we = 2'b10; addr1 = 16'h6010; wd1 = 8'hC3; req = 2'b10;
    run(20, na, nk, np);
    check("wr_ack_cycle", nk, 4);
    check("wr_ack",       {30'd0, ack}, 32'd2);
    check("wr_we_count",  we_cnt, 1);
    check("wr_we_addr",   {16'd0, we_addr}, 32'h6010);
    check("wr_we_data",   {24'd0, we_data}, 32'hC3);
    check("wr_rdata_keep",{24'd0, rdata}, 32'h5A);
    req = 2'b00; req_we = 2'b00;

    // Hold timeout.
    k = 0;
    while (pause_req && k < 40) begin
      step();
      k++;
    end
    check("hold_release", k, 16);
    check("hold_busy",    {31'd0, busy}, 32'd0);
    repeat (4) step();

    // Contention: both requesters held for 8 accesses.
    addr0 = 16'h6000; addr1 = 16'h6001; req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      run(60, na, nk, np);
      check("cont_ack",   {30'd0, ack}, {30'd0, exp_ack});
      check("cont_rdata", {24'd0, rdata}, (i % 2 == 0) ? 32'h5A : 32'h77);
      check("cont_plow",  np, 0);
      if (i > 0) check("cont_spacing", nk, 4);
    end
    req = 2'b00;

    // New request at idle cycle 10 of HOLD.
    prev_plow = 0;
    repeat (10) begin
      step();
      if (!pause_req) prev_plow++;
    end
    req = 2'b01;
    run(20, na, nk, np);
    check("hold_rearm_ack",  {30'd0, ack}, 32'd1);
    check("hold_rearm_cyc",  nk, 4);
    check("hold_rearm_plow", prev_plow + np, 0);
    req = 2'b00;

    // Settle glitch, cpu_paused driven by hand.
    k = 0;
    while (pause_req && k < 40) begin
      step();
      k++;
    end
    repeat (3) step();
    man_paused = 1'b0; man_mode = 1'b1;
    addr1 = 16'h6010; req = 2'b10;
    step();
    check("gl_pause", {31'd0, pause_req}, 32'd1);
    man_paused = 1'b1;
    k = 0;
    repeat (3) begin
      step();
      if (ram_access) k++;
    end
    man_paused = 1'b0;
    repeat (2) begin
      step();
      if (ram_access) k++;
    end
    check("gl_no_early_access", k, 0);
    man_paused = 1'b1;
    run(40, na, nk, np);
    check("gl_first_access", na, 6);
    check("gl_ack",          {30'd0, ack}, 32'd2);
    check("gl_rdata",        {24'd0, rdata}, 32'h00);
    req = 2'b00;
    man_mode = 1'b0;

    // Reset in the middle of an access.
    req = 2'b01;
    k = 0;
    while (!ram_access && k < 20) begin
      step();
      k++;
    end
    check("rs_reach_access", {31'd0, ram_access}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rs_access", {31'd0, ram_access}, 32'd0);
    check("rs_pause",  {31'd0, pause_req}, 32'd0);
    check("rs_ack",    {30'd0, ack}, 32'd0);
    check("rs_busy",   {31'd0, busy}, 32'd0);
    step();
    check("rs_ack_hold", {30'd0, ack}, 32'd0);
    reset = 1'b0;
    req = 2'b11;
    run(60, na, nk, np);
    check("rs_first_grant", {30'd0, ack}, 32'd1);
    req = 2'b00;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
